// File: rtl/id_fwd_scoreboard_pkg.sv
// Shared definitions for the decode-stage operand hazard unit.
//   - default register-file geometry (NREG/AW/DW)
//   - stage index encoding for the forwarding chain (EX youngest)
//   - latency class encoding produced by the decoder
package id_fwd_scoreboard_pkg;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef enum logic [1:0] {
        STG_EX = 2'd0,
        STG_ME = 2'd1,
        STG_WB = 2'd2
    } stg_idx_e;

    // ALU results are ready in EX, loads in ME, long ops leave the chain.
    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_LONG = 2'd2
    } lat_class_e;

    localparam int NSTG_DEF = 3;

endpackage

// File: rtl/id_fwd_scoreboard_fwd_select.sv
// Per-source operand resolution: youngest-wins stage bypass, long-unit
// same-cycle bypass, scoreboard check, register file fallback.
// Ports:
//   src_vld_i, src_addr_i, rf_rdata_i       - the source being resolved
//   stg_vld_i/stg_we_i/stg_rdy_i            - per-stage flags (bit 0 = EX)
//   stg_dest_i, stg_data_i                  - packed per-stage dest/result
//   lu_done_i, lu_waddr_i, lu_wdata_i       - long unit writeback
//   pend_i                                  - scoreboard bit for src_addr_i
//   val_o                                   - resolved operand value
//   hazard_o                                - operand not yet available
module fwd_select
    import id_fwd_scoreboard_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int NSTG = NSTG_DEF
) (
    input  logic               src_vld_i,
    input  logic [AW-1:0]      src_addr_i,
    input  logic [DW-1:0]      rf_rdata_i,
    input  logic [NSTG-1:0]    stg_vld_i,
    input  logic [NSTG-1:0]    stg_we_i,
    input  logic [NSTG-1:0]    stg_rdy_i,
    input  logic [NSTG*AW-1:0] stg_dest_i,
    input  logic [NSTG*DW-1:0] stg_data_i,
    input  logic               lu_done_i,
    input  logic [AW-1:0]      lu_waddr_i,
    input  logic [DW-1:0]      lu_wdata_i,
    input  logic               pend_i,
    output logic [DW-1:0]      val_o,
    output logic               hazard_o
);

    logic          hit;
    logic          hit_rdy;
    logic [DW-1:0] hit_data;

    // Scan oldest to youngest so the youngest matching stage overwrites.
    always_comb begin
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int i = NSTG - 1; i >= 0; i--) begin
            if (stg_vld_i[i] && stg_we_i[i] && (stg_dest_i[i*AW +: AW] == src_addr_i)) begin
                hit      = 1'b1;
                hit_rdy  = stg_rdy_i[i];
                hit_data = stg_data_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        val_o    = rf_rdata_i;
        hazard_o = 1'b0;
        if (src_addr_i == '0) begin
            val_o = '0;
        end else if (src_vld_i) begin
            if (hit) begin
                if (hit_rdy) begin
                    val_o = hit_data;
                end else begin
                    hazard_o = 1'b1;
                end
            end else if (lu_done_i && (lu_waddr_i == src_addr_i)) begin
                val_o = lu_wdata_i;
            end else if (pend_i) begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// Decode-stage operand hazard unit: N-stage forwarding, a scoreboard for one
// outstanding long-latency op, and a saturating stall-cycle counter.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   id_valid, id_fire               - ID occupancy and handshake
//   src_vld/src_addr/rf_rdata       - packed per-source read info
//   dst_we/dst_addr/dst_long        - ID instruction destination
//   stg_vld/stg_we/stg_rdy/stg_dest/stg_data - forwarding stages (0 = EX)
//   lu_done/lu_waddr/lu_wdata       - long unit writeback
//   src_val                         - resolved operands
//   stall, lu_busy, pend_map, stall_cnt - status outputs
module id_fwd_scoreboard
    import id_fwd_scoreboard_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int NSRC = 3,
    parameter int NSTG = NSTG_DEF,
    parameter int CNTW = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic               id_fire,
    input  logic [NSRC-1:0]    src_vld,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic [NSRC*DW-1:0] rf_rdata,
    input  logic               dst_we,
    input  logic [AW-1:0]      dst_addr,
    input  logic               dst_long,
    input  logic [NSTG-1:0]    stg_vld,
    input  logic [NSTG-1:0]    stg_we,
    input  logic [NSTG-1:0]    stg_rdy,
    input  logic [NSTG*AW-1:0] stg_dest,
    input  logic [NSTG*DW-1:0] stg_data,
    input  logic               lu_done,
    input  logic [AW-1:0]      lu_waddr,
    input  logic [DW-1:0]      lu_wdata,
    output logic [NSRC*DW-1:0] src_val,
    output logic               stall,
    output logic               lu_busy,
    output logic [NREG-1:0]    pend_map,
    output logic [CNTW-1:0]    stall_cnt
);

    logic [NREG-1:0] pend_map_q, pend_map_d;
    logic            lu_busy_q, lu_busy_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [NSRC-1:0] src_haz;
    logic            struct_haz;
    logic            waw_haz;
    logic            long_fire;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        fwd_select #(
            .AW   (AW),
            .DW   (DW),
            .NSTG (NSTG)
        ) u_fwd_select (
            .src_vld_i  (src_vld[s]),
            .src_addr_i (src_addr[s*AW +: AW]),
            .rf_rdata_i (rf_rdata[s*DW +: DW]),
            .stg_vld_i  (stg_vld),
            .stg_we_i   (stg_we),
            .stg_rdy_i  (stg_rdy),
            .stg_dest_i (stg_dest),
            .stg_data_i (stg_data),
            .lu_done_i  (lu_done),
            .lu_waddr_i (lu_waddr),
            .lu_wdata_i (lu_wdata),
            .pend_i     (pend_map_q[src_addr[s*AW +: AW]]),
            .val_o      (src_val[s*DW +: DW]),
            .hazard_o   (src_haz[s])
        );
    end

    // A completing long op frees both the unit and its destination this cycle.
    assign struct_haz = dst_long & lu_busy_q & ~lu_done;
    assign waw_haz    = dst_we & (dst_addr != '0) & pend_map_q[dst_addr]
                        & ~(lu_done & (lu_waddr == dst_addr));
    assign stall      = id_valid & ((|src_haz) | struct_haz | waw_haz);
    assign long_fire  = id_fire & dst_long;

    always_comb begin
        pend_map_d = pend_map_q;
        if (lu_done) begin
            pend_map_d[lu_waddr] = 1'b0;
        end
        // Applied after the clear so a new op to the same register keeps it pending.
        if (long_fire && dst_we && (dst_addr != '0)) begin
            pend_map_d[dst_addr] = 1'b1;
        end
        pend_map_d[0] = 1'b0;
    end

    always_comb begin
        lu_busy_d = lu_busy_q;
        if (long_fire) begin
            lu_busy_d = 1'b1;
        end else if (lu_done) begin
            lu_busy_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_valid && stall && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_map_q  <= '0;
            lu_busy_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            pend_map_q  <= pend_map_d;
            lu_busy_q   <= lu_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pend_map  = pend_map_q;
    assign lu_busy   = lu_busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
module tb_id_fwd_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NSRC = 3;
    localparam int NSTG = 3;
    localparam int CNTW = 32;
    localparam int SATW = 4;

    logic               clk;
    logic               reset;
    logic               id_valid;
    logic               id_fire;
    logic [NSRC-1:0]    src_vld;
    logic [NSRC*AW-1:0] src_addr;
    logic [NSRC*DW-1:0] rf_rdata;
    logic               dst_we;
    logic [AW-1:0]      dst_addr;
    logic               dst_long;
    logic [NSTG-1:0]    stg_vld;
    logic [NSTG-1:0]    stg_we;
    logic [NSTG-1:0]    stg_rdy;
    logic [NSTG*AW-1:0] stg_dest;
    logic [NSTG*DW-1:0] stg_data;
    logic               lu_done;
    logic [AW-1:0]      lu_waddr;
    logic [DW-1:0]      lu_wdata;
    logic [NSRC*DW-1:0] src_val;
    logic               stall;
    logic               lu_busy;
    logic [NREG-1:0]    pend_map;
    logic [CNTW-1:0]    stall_cnt;

    logic [NSRC*DW-1:0] s_src_val;
    logic               s_stall;
    logic               s_lu_busy;
    logic [NREG-1:0]    s_pend_map;
    logic [SATW-1:0]    s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_fwd_scoreboard #(
        .NREG(NREG), .AW(AW), .DW(DW), .NSRC(NSRC), .NSTG(NSTG), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_fire(id_fire),
        .src_vld(src_vld), .src_addr(src_addr), .rf_rdata(rf_rdata),
        .dst_we(dst_we), .dst_addr(dst_addr), .dst_long(dst_long),
        .stg_vld(stg_vld), .stg_we(stg_we), .stg_rdy(stg_rdy),
        .stg_dest(stg_dest), .stg_data(stg_data),
        .lu_done(lu_done), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .src_val(src_val), .stall(stall), .lu_busy(lu_busy),
        .pend_map(pend_map), .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a few cycles.
    id_fwd_scoreboard #(
        .NREG(NREG), .AW(AW), .DW(DW), .NSRC(NSRC), .NSTG(NSTG), .CNTW(SATW)
    ) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_fire(id_fire),
        .src_vld(src_vld), .src_addr(src_addr), .rf_rdata(rf_rdata),
        .dst_we(dst_we), .dst_addr(dst_addr), .dst_long(dst_long),
        .stg_vld(stg_vld), .stg_we(stg_we), .stg_rdy(stg_rdy),
        .stg_dest(stg_dest), .stg_data(stg_data),
        .lu_done(lu_done), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .src_val(s_src_val), .stall(s_stall), .lu_busy(s_lu_busy),
        .pend_map(s_pend_map), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_valid = 1'b0; id_fire = 1'b0;
        src_vld = '0; src_addr = '0; rf_rdata = '0;
        dst_we = 1'b0; dst_addr = '0; dst_long = 1'b0;
        stg_vld = '0; stg_we = '0; stg_rdy = '0; stg_dest = '0; stg_data = '0;
        lu_done = 1'b0; lu_waddr = '0; lu_wdata = '0;
    endtask

    // Advance one edge; inputs are then changed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [AW-1:0] a, input logic [DW-1:0] rf);
        src_vld[s]          = 1'b1;
        src_addr[s*AW +: AW] = a;
        rf_rdata[s*DW +: DW] = rf;
    endtask

    task automatic set_stg(input int i, input logic rdy, input logic [AW-1:0] d, input logic [DW-1:0] v);
        stg_vld[i]          = 1'b1;
        stg_we[i]           = 1'b1;
        stg_rdy[i]          = rdy;
        stg_dest[i*AW +: AW] = d;
        stg_data[i*DW +: DW] = v;
    endtask

    task automatic long_op(input logic [AW-1:0] d);
        clr();
        id_valid = 1'b1; id_fire = 1'b1;
        dst_we = 1'b1; dst_addr = d; dst_long = 1'b1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_pend", pend_map, 0);
        chk("rst_busy", lu_busy, 0);
        chk("rst_cnt", stall_cnt, 0);

        // ALU chain with a plain RF read and an unread r0 source
        clr();
        id_valid = 1'b1; id_fire = 1'b1;
        set_src(0, 5'd5, 32'hAAAA);
        set_src(1, 5'd6, 32'h66);
        rf_rdata[2*DW +: DW] = 32'h777;
        set_stg(0, 1'b1, 5'd5, 32'h11);
        #1;
        chk("alu_fwd", src_val[0 +: DW], 32'h11);
        chk("alu_rf", src_val[DW +: DW], 32'h66);
        chk("alu_r0", src_val[2*DW +: DW], 0);
        chk("alu_stall", stall, 0);
        step();
        chk("alu_cnt", stall_cnt, 0);

        // Load-use: youngest (EX, not ready) beats ME
        clr();
        id_valid = 1'b1;
        set_src(0, 5'd7, 32'hBBBB);
        set_stg(0, 1'b0, 5'd7, 32'hDEAD);
        set_stg(1, 1'b1, 5'd7, 32'h22);
        #1;
        chk("ld_stall", stall, 1);
        step();
        chk("ld_cnt1", stall_cnt, 1);
        clr();
        id_valid = 1'b1; id_fire = 1'b1;
        set_src(0, 5'd7, 32'hBBBB);
        set_stg(1, 1'b1, 5'd7, 32'h22);
        #1;
        chk("ld_fwd", src_val[0 +: DW], 32'h22);
        chk("ld_nostall", stall, 0);
        step();
        chk("ld_cnt2", stall_cnt, 1);

        // Long op to r9
        long_op(5'd9);
        #1;
        chk("div_stall", stall, 0);
        step();
        chk("div_pend", pend_map, 32'h0000_0200);
        chk("div_busy", lu_busy, 1);
        clr();
        id_valid = 1'b1;
        set_src(1, 5'd9, 32'h99);
        #1;
        chk("rd9_stall", stall, 1);
        step();
        chk("rd9_cnt", stall_cnt, 2);
        lu_done = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h33;
        id_fire = 1'b1;
        #1;
        chk("lu_byp", src_val[DW +: DW], 32'h33);
        chk("lu_nostall", stall, 0);
        step();
        clr();
        #1;
        chk("lu_pend_clr", pend_map, 0);
        chk("lu_busy_clr", lu_busy, 0);

        // Structural and WAW hazards
        long_op(5'd9);
        step();
        long_op(5'd10);
        id_fire = 1'b0;
        #1;
        chk("struct_stall", stall, 1);
        step();
        chk("struct_cnt", stall_cnt, 3);
        clr();
        id_valid = 1'b1; dst_we = 1'b1; dst_addr = 5'd9;
        #1;
        chk("waw_stall", stall, 1);
        step();
        chk("waw_cnt", stall_cnt, 4);
        lu_done = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h44;
        #1;
        chk("waw_release", stall, 0);
        id_fire = 1'b1;
        step();
        clr();
        #1;
        chk("waw_pend", pend_map, 0);
        chk("waw_busy", lu_busy, 0);

        // Completion and new long op on the same register in one cycle
        long_op(5'd4);
        step();
        chk("sim_pend0", pend_map, 32'h0000_0010);
        long_op(5'd4);
        lu_done = 1'b1; lu_waddr = 5'd4; lu_wdata = 32'h55;
        #1;
        chk("sim_stall", stall, 0);
        step();
        chk("sim_pend", pend_map, 32'h0000_0010);
        chk("sim_busy", lu_busy, 1);
        clr();
        lu_done = 1'b1; lu_waddr = 5'd4;
        step();
        clr();
        #1;
        chk("sim_pend_clr", pend_map, 0);
        chk("sim_busy_clr", lu_busy, 0);

        // Stray writeback while idle leaves busy low
        lu_done = 1'b1; lu_waddr = 5'd3;
        step();
        clr();
        #1;
        chk("stray_busy", lu_busy, 0);

        // r0 reads with every stage targeting r0
        clr();
        id_valid = 1'b1;
        set_src(0, 5'd0, 32'h1234);
        set_src(2, 5'd0, 32'h5678);
        set_stg(0, 1'b0, 5'd0, 32'hA0);
        set_stg(1, 1'b0, 5'd0, 32'hA1);
        set_stg(2, 1'b1, 5'd0, 32'hA2);
        #1;
        chk("r0_val", src_val[0 +: DW], 0);
        chk("r0_val2", src_val[2*DW +: DW], 0);
        chk("r0_stall", stall, 0);
        step();
        chk("r0_cnt", stall_cnt, 4);

        // Reset in the middle of a long op
        long_op(5'd12);
        step();
        chk("mid_pend", pend_map, 32'h0000_1000);
        clr();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_pend", pend_map, 0);
        chk("mid_rst_busy", lu_busy, 0);
        chk("mid_rst_cnt", stall_cnt, 0);

        // Saturation: hold a load-use stall for 20 cycles
        clr();
        id_valid = 1'b1;
        set_src(0, 5'd8, 32'h88);
        set_stg(0, 1'b0, 5'd8, 32'h0);
        for (int k = 0; k < 15; k++) step();
        chk("sat_cnt15", s_stall_cnt, 4'hF);
        chk("main_cnt15", stall_cnt, 15);
        for (int k = 0; k < 5; k++) step();
        chk("sat_hold", s_stall_cnt, 4'hF);
        chk("main_cnt20", stall_cnt, 20);

        clr();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_fwd_scoreboard.md
# id_fwd_scoreboard

Parametrised operand-hazard unit for the decode stage. It replaces the fixed EX/ME/WB compare-and-forward logic with an N-stage youngest-wins bypass network. It adds a register scoreboard for one outstanding long-latency operation (divide/multi-cycle multiply) that completes out of the stage chain, and a saturating stall-cycle counter. It sits between the register file read ports and the ID-to-EX bus, and drives the ID stage's ready-go.

## Interface
- `NREG`, default 32: architectural register count; register 0 is hard-wired zero.
- `AW`, default 5: register address width, equal to clog2(NREG).
- `DW`, default 32: data width.
- `NSRC`, default 3: source operands per instruction (rj, rk, rd).
- `NSTG`, default 3: forwarding stages after ID. Index 0 is the youngest (EX), then ME, then WB.
- `CNTW`, default 32: stall counter width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `id_valid` in 1: ID holds a valid instruction.
- `id_fire` in 1: instruction leaves ID this cycle. Must equal id_valid & ~stall & ex_allow_in.
- `src_vld` in NSRC: per-source "operand is read".
- `src_addr` in NSRC*AW: packed source addresses; source s occupies bits [s*AW +: AW].
- `rf_rdata` in NSRC*DW: register file read data per source.
- `dst_we` in 1: ID instruction writes a register.
- `dst_addr` in AW: ID instruction destination.
- `dst_long` in 1: ID instruction goes to the long-latency unit.
- `stg_vld`, `stg_we`, `stg_rdy` in NSTG each: per stage, valid, writes a register, and result available this cycle.
- `stg_dest` in NSTG*AW: per-stage destination.
- `stg_data` in NSTG*DW: per-stage result.
- `lu_done` in 1: long unit writes back this cycle.
- `lu_waddr` in AW: long unit writeback address.
- `lu_wdata` in DW: long unit writeback data.
- `src_val` out NSRC*DW: resolved operand values.
- `stall` out 1: ID must not advance.
- `lu_busy` out 1: a long operation is outstanding.
- `pend_map` out NREG: scoreboard bits; bit 0 is always 0.
- `stall_cnt` out CNTW: saturating count of cycles with id_valid & stall.

## Operation
- **Per-source resolution**, for each s with src_vld[s] and src_addr[s] != 0, highest priority first:
  - Youngest stage i with stg_vld & stg_we & stg_dest == addr. If stg_rdy[i], output stg_data[i]; else raise hazard.
  - Else, if lu_done and lu_waddr == addr: output lu_wdata. This is a same-cycle bypass; no stall.
  - Else, if pend_map[addr]: raise hazard.
  - Else: output rf_rdata[s].
- Sources with src_vld = 0 or address 0: src_val = rf_rdata when address != 0, and 0 when address = 0. They never stall.
- **Structural hazard:** dst_long & lu_busy & ~lu_done.
- **WAW hazard:** dst_we & dst_addr != 0 & pend_map[dst_addr] & ~(lu_done & lu_waddr == dst_addr).
- **stall** = id_valid & (any source hazard | structural | WAW).
- **Scoreboard update per cycle:**
  - Clear pend_map[lu_waddr] on lu_done.
  - Then set pend_map[dst_addr] on id_fire & dst_long & dst_we & dst_addr != 0.
  - Set wins if both hit the same address.
- **lu_busy:** set on id_fire & dst_long; cleared on lu_done unless a new long op fires in the same cycle.
- A long op with dst_we = 0 sets lu_busy only.
- **stall_cnt:** increments when id_valid & stall; holds at all-ones.
- lu_done while lu_busy = 0 is ignored by lu_busy. pend_map is still cleared.

## Timing
- Hazard detection, forwarding and stall are combinational within one cycle. There is no added latency on the operand path.
- Scoreboard, lu_busy and stall_cnt update on the rising edge.
- Reset values: pend_map = 0, lu_busy = 0, stall_cnt = 0. Combinational outputs follow their inputs.
- Reset in the middle of a long operation drops all pending state. The long unit is reset in the same cycle.
- **Latency cases:**
  - A dependent instruction behind a long op stalls until the lu_done cycle and proceeds in that same cycle.
  - Load-use: the consumer stalls exactly 1 cycle, assuming stage 0 has stg_rdy = 0 and stage 1 has stg_rdy = 1.

## Structure
- Shared package: AW/DW/NREG constants, the stage index enum (STG_EX = 0, STG_ME = 1, STG_WB = 2), and the lat-class encoding used by the decoder.
- One sub-module, `fwd_select`, instantiated NSRC times. It does the per-source priority mux and hazard flag.
- The scoreboard, busy flag and counter stay in the top level.

## Test plan
- **ALU chain:** add r5 in EX with stg_rdy = 1 and data 0x11; ID reads rj = r5 -> src_val = 0x11, stall = 0.
- **Load-use:** EX holds ld to r7 (stg_rdy = 0), ME holds r7 = 0x22; ID reads r7 -> stall = 1, youngest wins. Next cycle r7 is in ME with rdy = 1 -> forwards 0x22, stall_cnt = 1.
- **Long op:**
  - div to r9 fires -> pend_map[9] = 1, lu_busy = 1.
  - A reader of r9 stalls.
  - lu_done with r9 = 0x33 -> same-cycle src_val = 0x33, stall = 0; pend_map[9] = 0 next cycle.
- **Structural/WAW:**
  - A second div while busy -> stall.
  - An add to r9 while r9 is pending -> stall; released on lu_done.
- **Simultaneous:** lu_done clears r4 while a new div to r4 fires -> pend_map[4] = 1, lu_busy = 1.
- **Boundaries:**
  - Reading r0 with all stages writing r0 -> src_val = 0, no stall.
  - Force stall_cnt to 0xFFFFFFFF, then stall -> stays at 0xFFFFFFFF.
  - Reset mid-div -> pend_map = 0, lu_busy = 0.
